// File: rtl/sdram_host_port_if.sv
// Request bus between the host port (master) and the SDRAM memory controller (slave).
interface sdram_host_port_if;
  logic        mc_read;
  logic        mc_write;
  logic        mc_refresh;
  logic [23:0] mc_addr;
  logic [15:0] mc_din;
  logic [1:0]  mc_wdm;
  logic [15:0] mc_dout;
  logic        mc_busy;

  modport master (
    output mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm,
    input  mc_dout, mc_busy
  );

  modport slave (
    input  mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm,
    output mc_dout, mc_busy
  );
endinterface

// File: rtl/sdram_host_port.sv
// Byte-wide CPU to 16-bit SDRAM controller bridge with periodic auto-refresh arbitration.
module sdram_host_port #(
  parameter int unsigned REFRESH_CYCLES = 810,
  parameter int unsigned ISSUE_TIMEOUT  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [23:0]       cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic              refresh_miss,
  output logic              timeout_err,
  sdram_host_port_if.master mc
);

  localparam int unsigned RefW = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [RefW-1:0] RefReload = RefW'(REFRESH_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast    = ToW'(ISSUE_TIMEOUT - 1);

  typedef enum logic [2:0] {StInit, StIdle, StIssue, StWaitHi, StWaitLo, StDone} state_e;
  typedef enum logic [1:0] {OpRead, OpWrite, OpRefresh} op_e;

  state_e          state_q;
  op_e             op_q;
  logic [23:0]     addr_q;
  logic [7:0]      din_q;
  logic [RefW-1:0] ref_cnt_q;
  logic            ref_pend_q;
  logic [ToW-1:0]  to_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StInit;
      op_q          <= OpRead;
      addr_q        <= '0;
      din_q         <= '0;
      ref_cnt_q     <= RefReload;
      ref_pend_q    <= 1'b0;
      to_cnt_q      <= '0;
      mc.mc_read    <= 1'b0;
      mc.mc_write   <= 1'b0;
      mc.mc_refresh <= 1'b0;
      mc.mc_addr    <= '0;
      mc.mc_din     <= '0;
      mc.mc_wdm     <= 2'b00;
      cpu_dout      <= '0;
      cpu_ready     <= 1'b0;
      cpu_ack       <= 1'b0;
      refresh_miss  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      mc.mc_read    <= 1'b0;
      mc.mc_write   <= 1'b0;
      mc.mc_refresh <= 1'b0;
      cpu_ack       <= 1'b0;

      unique case (state_q)
        StInit: begin
          if (!mc.mc_busy) begin
            state_q   <= StIdle;
            cpu_ready <= 1'b1;
          end
        end
        StIdle: begin
          if (ref_pend_q) begin
            op_q       <= OpRefresh;
            ref_pend_q <= 1'b0;
            cpu_ready  <= 1'b0;
            state_q    <= StIssue;
          end else if (cpu_req) begin
            op_q      <= cpu_we ? OpWrite : OpRead;
            addr_q    <= cpu_addr;
            din_q     <= cpu_din;
            cpu_ready <= 1'b0;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (!mc.mc_busy) begin
            mc.mc_read    <= (op_q == OpRead);
            mc.mc_write   <= (op_q == OpWrite);
            mc.mc_refresh <= (op_q == OpRefresh);
            mc.mc_addr    <= {1'b0, addr_q[23:1]};
            mc.mc_din     <= {din_q, din_q};
            // Mask the lane that is not being written.
            mc.mc_wdm     <= (op_q == OpWrite) ? (addr_q[0] ? 2'b01 : 2'b10) : 2'b00;
            to_cnt_q      <= '0;
            state_q       <= StWaitHi;
          end
        end
        StWaitHi: begin
          if (mc.mc_busy) begin
            state_q <= StWaitLo;
          end else if (to_cnt_q == ToLast) begin
            timeout_err <= 1'b1;
            if (op_q == OpRead) cpu_dout <= 8'hFF;
            cpu_ack <= (op_q != OpRefresh);
            state_q <= StDone;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end
        StWaitLo: begin
          if (!mc.mc_busy) begin
            if (op_q == OpRead) cpu_dout <= addr_q[0] ? mc.mc_dout[15:8] : mc.mc_dout[7:0];
            cpu_ack <= (op_q != OpRefresh);
            state_q <= StDone;
          end
        end
        StDone: begin
          cpu_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StInit;
      endcase

      // Placed after the FSM so an expiry in the same cycle as a grant keeps the new request.
      if (state_q != StInit) begin
        if (ref_cnt_q == '0) begin
          ref_cnt_q  <= RefReload;
          ref_pend_q <= 1'b1;
          if (ref_pend_q) refresh_miss <= 1'b1;
        end else begin
          ref_cnt_q <= ref_cnt_q - RefW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_host_port.sv
// Directed bench for sdram_host_port with a simple busy-pulse controller model.
module tb_sdram_host_port;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ready;
  logic        cpu_ack;
  logic        refresh_miss;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_host_port_if bus ();

  sdram_host_port #(
    .REFRESH_CYCLES(16),
    .ISSUE_TIMEOUT (3)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_ready   (cpu_ready),
    .cpu_ack     (cpu_ack),
    .refresh_miss(refresh_miss),
    .timeout_err (timeout_err),
    .mc          (bus)
  );

  // Controller model: busy for 5 cycles starting the cycle after it sees a strobe.
  logic        force_busy = 1'b0;
  logic        auto_busy = 1'b1;
  int unsigned busy_cnt = 0;
  assign bus.mc_busy = force_busy | (auto_busy & (busy_cnt != 0));
  assign bus.mc_dout = 16'h3C7E;

  always @(posedge clk) begin
    if (!resetn) busy_cnt <= 0;
    else if (bus.mc_read | bus.mc_write | bus.mc_refresh) busy_cnt <= 5;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Observation results, cycle k=1 is the cycle after the request-sampling edge.
  int          ack_at, terr_at, n_rd, n_wr, n_ref, n_ack;
  int          ref_k[$];
  logic [7:0]  dout_at_ack;
  logic        ready_at_ack, ready_after;
  logic [23:0] cap_addr;
  logic [15:0] cap_din;
  logic [1:0]  cap_wdm;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input int cycles);
    ack_at = -1; terr_at = -1; n_rd = 0; n_wr = 0; n_ref = 0; n_ack = 0;
    ref_k.delete();
    ready_at_ack = 1'b0; ready_after = 1'b0; dout_at_ack = '0;
    for (int k = 1; k <= cycles; k++) begin
      step();
      if (bus.mc_read)    n_rd++;
      if (bus.mc_write)   n_wr++;
      if (bus.mc_refresh) begin n_ref++; ref_k.push_back(k); end
      if (bus.mc_read | bus.mc_write) begin
        cap_addr = bus.mc_addr; cap_din = bus.mc_din; cap_wdm = bus.mc_wdm;
      end
      if (cpu_ack) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at = k; dout_at_ack = cpu_dout; ready_at_ack = cpu_ready;
        end
      end
      if (ack_at >= 0 && k == ack_at + 1) ready_after = cpu_ready;
      if (timeout_err && terr_at < 0) terr_at = k;
    end
  endtask

  task automatic cpu_op(input logic we, input logic [23:0] addr, input logic [7:0] din,
                        input int cycles);
    cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    observe(cycles);
  endtask

  task automatic reset_and_init();
    bit seen;
    seen = 1'b0;
    resetn = 1'b0; cpu_req = 1'b0; force_busy = 1'b0; auto_busy = 1'b1;
    step(); step();
    resetn = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = cpu_ready;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL init_ready: cpu_ready never rose within 10 cycles"); end
  endtask

  task automatic test_reset();
    resetn = 1'b0; force_busy = 1'b1; cpu_req = 1'b0;
    repeat (4) step();
    checks++;
    if ({cpu_ready, cpu_ack, refresh_miss, timeout_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000",
                         {cpu_ready, cpu_ack, refresh_miss, timeout_err});
    end
    checks++;
    if ({bus.mc_read, bus.mc_write, bus.mc_refresh, bus.mc_wdm} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000",
                         {bus.mc_read, bus.mc_write, bus.mc_refresh, bus.mc_wdm});
    end
    checks++;
    if ({bus.mc_addr, bus.mc_din, cpu_dout} !== 48'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus.mc_addr, bus.mc_din, cpu_dout});
    end
    resetn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      checks++;
      if ({cpu_ready, bus.mc_read, bus.mc_write, bus.mc_refresh} !== 4'b0000) begin
        errors++; $display("FAIL init_hold: cycle %0d got %b expected 0000", k,
                           {cpu_ready, bus.mc_read, bus.mc_write, bus.mc_refresh});
      end
    end
    force_busy = 1'b0;
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL init_early: cpu_ready got %b expected 0", cpu_ready); end
    step();
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL init_rise: cpu_ready got %b expected 1", cpu_ready); end
  endtask

  task automatic test_write();
    reset_and_init();
    cpu_op(1'b1, 24'h000101, 8'hA5, 12);
    checks++;
    if (ack_at != 8) begin errors++; $display("FAIL write_latency: got %0d expected 8", ack_at); end
    checks++;
    if ({n_wr, n_rd, n_ref, n_ack} != {32'd1, 32'd0, 32'd0, 32'd1}) begin
      errors++; $display("FAIL write_counts: wr %0d rd %0d ref %0d ack %0d expected 1 0 0 1",
                         n_wr, n_rd, n_ref, n_ack);
    end
    checks++;
    if (cap_addr !== 24'h000080) begin errors++; $display("FAIL write_addr: got %h expected 000080", cap_addr); end
    checks++;
    if (cap_din !== 16'hA5A5) begin errors++; $display("FAIL write_din: got %h expected a5a5", cap_din); end
    checks++;
    if (cap_wdm !== 2'b01) begin errors++; $display("FAIL write_wdm: got %b expected 01", cap_wdm); end
    checks++;
    if ({ready_at_ack, ready_after} !== 2'b01) begin
      errors++; $display("FAIL write_ready: got %b expected 01", {ready_at_ack, ready_after});
    end
  endtask

  task automatic test_read();
    reset_and_init();
    cpu_op(1'b0, 24'h000100, 8'h00, 12);
    checks++;
    if (ack_at != 8) begin errors++; $display("FAIL read0_latency: got %0d expected 8", ack_at); end
    checks++;
    if (dout_at_ack !== 8'h7E) begin errors++; $display("FAIL read0_data: got %h expected 7e", dout_at_ack); end
    checks++;
    if ({cap_addr, cap_wdm} !== {24'h000080, 2'b00}) begin
      errors++; $display("FAIL read0_bus: got %h/%b expected 000080/00", cap_addr, cap_wdm);
    end
    reset_and_init();
    cpu_op(1'b0, 24'h000101, 8'h00, 12);
    checks++;
    if (dout_at_ack !== 8'h3C) begin errors++; $display("FAIL read1_data: got %h expected 3c", dout_at_ack); end
    checks++;
    if (cpu_dout !== 8'h3C) begin errors++; $display("FAIL read1_hold: got %h expected 3c", cpu_dout); end
  endtask

  task automatic test_refresh();
    reset_and_init();
    observe(60);
    checks++;
    if (ref_k.size() != 3) begin
      errors++; $display("FAIL refresh_count: got %0d expected 3", ref_k.size());
    end else begin
      checks++;
      if (ref_k[0] != 18 || ref_k[1] != 34 || ref_k[2] != 50) begin
        errors++; $display("FAIL refresh_period: got %0d %0d %0d expected 18 34 50",
                           ref_k[0], ref_k[1], ref_k[2]);
      end
    end
    checks++;
    if ({n_ack, n_rd, n_wr} != 96'd0 || refresh_miss !== 1'b0) begin
      errors++; $display("FAIL refresh_side: ack %0d rd %0d wr %0d miss %b expected 0 0 0 0",
                         n_ack, n_rd, n_wr, refresh_miss);
    end
  endtask

  task automatic test_conflict();
    reset_and_init();
    repeat (16) step();
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready: got %b expected 1", cpu_ready); end
    cpu_op(1'b0, 24'h000200, 8'h00, 14);
    checks++;
    if (n_ref != 1 || ref_k.size() == 0 || ref_k[0] != 1) begin
      errors++; $display("FAIL conflict_refresh: count %0d expected 1 at cycle 1", n_ref);
    end
    checks++;
    if (n_rd != 0 || n_ack != 0) begin
      errors++; $display("FAIL conflict_drop: rd %0d ack %0d expected 0 0", n_rd, n_ack);
    end
    // Refresh miss: controller held busy so pending refreshes pile up.
    reset_and_init();
    force_busy = 1'b1;
    repeat (40) step();
    checks++;
    if (refresh_miss !== 1'b0) begin errors++; $display("FAIL miss_early: got %b expected 0", refresh_miss); end
    force_busy = 1'b0;
    repeat (20) step();
    checks++;
    if (refresh_miss !== 1'b1) begin errors++; $display("FAIL miss_set: got %b expected 1", refresh_miss); end
  endtask

  task automatic test_timeout();
    reset_and_init();
    auto_busy = 1'b0;
    cpu_op(1'b0, 24'h000100, 8'h00, 8);
    auto_busy = 1'b1;
    checks++;
    if (terr_at != 4) begin errors++; $display("FAIL timeout_at: got %0d expected 4", terr_at); end
    checks++;
    if (ack_at != 4 || n_ack != 1) begin
      errors++; $display("FAIL timeout_ack: at %0d count %0d expected 4 1", ack_at, n_ack);
    end
    checks++;
    if (dout_at_ack !== 8'hFF) begin errors++; $display("FAIL timeout_dout: got %h expected ff", dout_at_ack); end
    checks++;
    if ({ready_at_ack, ready_after} !== 2'b01) begin
      errors++; $display("FAIL timeout_ready: got %b expected 01", {ready_at_ack, ready_after});
    end
  endtask

  task automatic test_reset_mid();
    reset_and_init();
    cpu_op(1'b1, 24'h000010, 8'h11, 3);
    resetn = 1'b0;
    observe(2);
    resetn = 1'b1;
    begin
      int acks;
      acks = n_ack;
      observe(12);
      acks += n_ack;
      checks++;
      if (acks != 0) begin errors++; $display("FAIL reset_mid_ack: got %0d expected 0", acks); end
    end
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b expected 1", cpu_ready); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_refresh();
    test_conflict();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_host_port.md
Name: sdram_host_port

Overview:
- Host-side initiator for the SDRAM memory controller's request interface (read/write/refresh/busy/addr/din/wdm/dout).
- Converts byte-wide CPU accesses into 16-bit word transactions with byte masks.
- Generates periodic auto-refresh requests and arbitrates them against CPU traffic.
- Sits between the MSX CPU/bus glue and the memory controller.

Parameters:
- REFRESH_CYCLES, 810, clk cycles between refresh requests (15 us at 54 MHz).
- ISSUE_TIMEOUT, 3, max cycles to wait for mc_busy to rise after a strobe before flagging an error.

Ports:
- clk  in  1  main logic clock.
- resetn  in  1  synchronous, active-low reset.
- cpu_req  in  1  single-cycle request strobe; honoured only while cpu_ready=1.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  24  byte address; word address is cpu_addr[23:1], byte lane is cpu_addr[0].
- cpu_din  in  8  write byte; sampled with cpu_req.
- cpu_dout  out  8  read byte; valid from the cpu_ack cycle until the next accepted read.
- cpu_ready  out  1  1 = idle and able to accept cpu_req.
- cpu_ack  out  1  one-cycle pulse when the CPU access completes.
- mc_read  out  1  read strobe to memory controller.
- mc_write  out  1  write strobe to memory controller.
- mc_refresh  out  1  refresh strobe to memory controller.
- mc_addr  out  24  word address = {1'b0, cpu_addr[23:1]}.
- mc_din  out  16  {cpu_din, cpu_din}.
- mc_wdm  out  2  write byte mask, active-high masks the lane.
- mc_dout  in  16  read data from memory controller.
- mc_busy  in  1  memory controller busy.
- refresh_miss  out  1  sticky: a refresh interval expired while a refresh was still pending.
- timeout_err  out  1  sticky: mc_busy did not rise within ISSUE_TIMEOUT cycles of a strobe.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - State goes to INIT.
  - All mc_* strobes 0, mc_addr 0, mc_din 0, mc_wdm 2'b00.
  - cpu_dout 0, cpu_ready 0, cpu_ack 0, refresh_miss 0, timeout_err 0.
  - Refresh counter loads REFRESH_CYCLES-1; refresh_pending cleared.
  - Reset mid-transaction abandons it with no ack.
- States: INIT, IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
- INIT:
  - Wait for mc_busy=0 (controller initialisation done), then go to IDLE with cpu_ready=1.
  - Refresh counter is frozen in INIT.
- Refresh timer (all states except INIT):
  - Decrements every cycle.
  - At 0: reloads REFRESH_CYCLES-1 and sets refresh_pending.
  - If refresh_pending is already 1 at expiry, set refresh_miss. Only one refresh is ever pending.
- IDLE arbitration, evaluated each cycle:
  - If refresh_pending=1: latch a refresh op, clear refresh_pending, cpu_ready=0, go to ISSUE. Refresh wins over a same-cycle cpu_req; that cpu_req is dropped (no ack), because cpu_ready was 1 that cycle but the refresh had priority.
  - Else if cpu_req=1: latch cpu_we, addr, din and lane; cpu_ready=0; go to ISSUE.
- ISSUE:
  - Proceed only when mc_busy=0. While mc_busy=1, hold in ISSUE with no strobe.
  - Pulse exactly one strobe for one cycle (mc_read, mc_write or mc_refresh), with mc_addr/mc_din/mc_wdm valid in the same cycle, then go to WAIT_HI.
  - Write mask: lane 0 gives mc_wdm=2'b10; lane 1 gives mc_wdm=2'b01.
  - Read and refresh use mc_wdm=2'b00.
- WAIT_HI:
  - When mc_busy=1, go to WAIT_LO.
  - If ISSUE_TIMEOUT cycles elapse first, set timeout_err and go to DONE. A read returns cpu_dout=8'hFF.
- WAIT_LO:
  - When mc_busy=0, capture mc_dout in that same cycle (read only): lane 0 gives mc_dout[7:0], lane 1 gives mc_dout[15:8]. Go to DONE.
- DONE:
  - cpu_ack=1 for CPU ops only; refresh ops produce no ack.
  - Next cycle: IDLE with cpu_ready=1.
- Nominal CPU latency: with the controller's 5-cycle busy, cpu_ack arrives 8 cycles after the accepted cpu_req.
- Strobes never overlap; at most one transaction is outstanding.

Test Plan:
- Reset held 4 cycles, mc_busy=1 for 20 cycles then 0 -> cpu_ready rises exactly 1 cycle after mc_busy falls; no strobes before that.
- Write addr 24'h000101, din 8'hA5 -> one mc_write pulse with mc_addr 24'h000080, mc_din 16'hA5A5, mc_wdm 2'b01; cpu_ack 8 cycles after cpu_req.
- Read addr 24'h000100 with model returning mc_dout 16'h3C7E -> cpu_dout 8'h7E at cpu_ack. Read addr 24'h000101 -> 8'h3C.
- REFRESH_CYCLES=16, idle bus -> mc_refresh pulses every 16 cycles, no cpu_ack, refresh_miss stays 0.
- Refresh expiry coincides with cpu_req -> mc_refresh is issued first and the CPU request is dropped. Then hold mc_busy=1 for 40 cycles with REFRESH_CYCLES=16 -> refresh_miss=1.
- Model never raises mc_busy after a read strobe -> timeout_err=1 after 3 cycles, cpu_dout 8'hFF, cpu_ack pulses, and cpu_ready returns the next cycle.
